// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU protocol: sends op/A/B bytes into the TX FIFO,
// then waits for one result byte from the RX FIFO or reports a timeout.
module uart_alu_host #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned NB_TO   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [NB_OP-1:0] i_op,
  input  logic [DBIT-1:0]  i_a,
  input  logic [DBIT-1:0]  i_b,
  output logic             o_wr_uart,
  output logic [DBIT-1:0]  o_w_data,
  input  logic             i_tx_full,
  output logic             o_rd_uart,
  input  logic [DBIT-1:0]  i_r_data,
  input  logic             i_rx_empty,
  output logic             o_rsp_valid,
  output logic [DBIT-1:0]  o_result,
  output logic             o_timeout
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_OP  = 3'd1;
  localparam logic [2:0] SEND_A   = 3'd2;
  localparam logic [2:0] SEND_B   = 3'd3;
  localparam logic [2:0] WAIT_RSP = 3'd4;

  localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [NB_TO-1:0] cnt_q, cnt_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [DBIT-1:0]  a_q, a_d, b_q, b_d;
  logic             wr_q, wr_d;
  logic [DBIT-1:0]  wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic             rsp_q, rsp_d;
  logic [DBIT-1:0]  result_q, result_d;
  logic             to_q, to_d;
  logic             cmd_ready;

  assign cmd_ready   = (state_q == IDLE) & i_rx_empty & ~rd_q & ~reset;
  assign o_cmd_ready = cmd_ready;

  // A write may only issue when no write was issued last cycle, so the FIFO full flag
  // has had a cycle to reflect the previous byte.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;
    rd_d     = 1'b0;
    rsp_d    = 1'b0;
    result_d = result_q;
    to_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid && cmd_ready) begin
          op_d    = i_op;
          a_d     = i_a;
          b_d     = i_b;
          state_d = SEND_OP;
        end else if (!i_rx_empty && !rd_q) begin
          rd_d = 1'b1;
        end
      end
      SEND_OP: begin
        if (!i_tx_full && !wr_q) begin
          wr_d               = 1'b1;
          wdata_d            = '0;
          wdata_d[NB_OP-1:0] = op_q;
          state_d            = SEND_A;
        end
      end
      SEND_A: begin
        if (!i_tx_full && !wr_q) begin
          wr_d    = 1'b1;
          wdata_d = a_q;
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        if (!i_tx_full && !wr_q) begin
          wr_d    = 1'b1;
          wdata_d = b_q;
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        // A byte arriving on the terminal count still wins over the timeout.
        if (!i_rx_empty) begin
          rd_d     = 1'b1;
          rsp_d    = 1'b1;
          result_d = i_r_data;
          state_d  = IDLE;
        end else if (cnt_q == TO_LAST) begin
          rsp_d    = 1'b1;
          to_d     = 1'b1;
          result_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      rsp_q    <= 1'b0;
      result_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      rsp_q    <= rsp_d;
      result_q <= result_d;
      to_q     <= to_d;
    end
  end

  assign o_wr_uart   = wr_q;
  assign o_w_data    = wdata_q;
  assign o_rd_uart   = rd_q;
  assign o_rsp_valid = rsp_q;
  assign o_result    = result_q;
  assign o_timeout   = to_q;

endmodule
